// File: rtl/fir_mac_serial_if.sv
// ----------------------------------------------------------------------------
// fir_mac_serial_if
//   Bus between the FIR tap/coefficient shift register (master) and the
//   serial MAC stage (slave).
//   master drives : start, x_mag, x_sign, c_mag, c_sign
//   slave drives  : busy, y_valid, y_out, sat
//   Tap i magnitude lives at [i*BW_in +: BW_in]; tap i sign at bit i.
// ----------------------------------------------------------------------------
interface fir_mac_serial_if #(
   parameter int N_TAPS = 5,
   parameter int BW_in  = 6,
   parameter int BW_out = 8
);
   logic                       start;
   logic [N_TAPS*BW_in-1:0]    x_mag;
   logic [N_TAPS-1:0]          x_sign;
   logic [N_TAPS*BW_in-1:0]    c_mag;
   logic [N_TAPS-1:0]          c_sign;
   logic                       busy;
   logic                       y_valid;
   logic [BW_out-1:0]          y_out;
   logic                       sat;

   modport master (
      output start, x_mag, x_sign, c_mag, c_sign,
      input  busy, y_valid, y_out, sat
   );

   modport slave (
      input  start, x_mag, x_sign, c_mag, c_sign,
      output busy, y_valid, y_out, sat
   );
endinterface

// File: rtl/fir_mac_serial.sv
// ----------------------------------------------------------------------------
// fir_mac_serial
//   Serial sign-magnitude multiply-accumulate. On start (in IDLE) the tap
//   samples/coefficients are snapshotted, then one tap per clock is multiplied
//   and accumulated. The sum is arithmetically right-shifted by SHIFT,
//   saturated to a signed BW_out result and presented with a 1-cycle valid.
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : fir_mac_serial_if.slave
//            start in; x_mag/x_sign/c_mag/c_sign in;
//            busy, y_valid, y_out, sat out
// ----------------------------------------------------------------------------
module fir_mac_serial #(
   parameter int N_TAPS = 5,
   parameter int BW_in  = 6,
   parameter int BW_out = 8,
   parameter int SHIFT  = 4
) (
   input  logic             clk,
   input  logic             reset,
   fir_mac_serial_if.slave  bus
);

   localparam int PROD_W = 2*BW_in;
   // Worst case |sum| = N_TAPS*(2^BW_in-1)^2, so this width cannot overflow.
   localparam int ACC_W  = PROD_W + $clog2(N_TAPS) + 1;
   localparam int IDX_W  = $clog2(N_TAPS+1);
   // Compare in a width that holds both the shifted sum and the output range.
   localparam int WIDE   = ((ACC_W > BW_out) ? ACC_W : BW_out) + 1;

   localparam logic [IDX_W-1:0]     LAST  = IDX_W'(N_TAPS-1);
   localparam logic signed [WIDE-1:0] Y_MAX = WIDE'((2**(BW_out-1)) - 1);
   localparam logic signed [WIDE-1:0] Y_MIN = -Y_MAX - WIDE'(1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t state_q, state_d;
   logic   load, mac_en, out_en;

   // snapshot of the tap vectors, frozen for the whole evaluation
   logic [N_TAPS-1:0][BW_in-1:0] xm_q, cm_q;
   logic [N_TAPS-1:0]            xs_q, cs_q;

   logic [IDX_W-1:0]         idx_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     y_valid_q;
   logic [BW_out-1:0]        y_out_q;
   logic                     sat_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      mac_en  = 1'b0;
      out_en  = 1'b0;
      case (state_q)
         S_IDLE: if (bus.start) begin
            load    = 1'b1;
            state_d = S_MAC;
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (idx_q == LAST) state_d = S_OUT;
         end
         S_OUT: begin
            out_en  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- tap select + multiply ----------------
   logic [BW_in-1:0]        sel_xm, sel_cm;
   logic                    sel_neg;
   logic [PROD_W-1:0]       prod;
   logic signed [ACC_W-1:0] term;

   always_comb begin
      sel_xm  = '0;
      sel_cm  = '0;
      sel_neg = 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_xm  = xm_q[i];
            sel_cm  = cm_q[i];
            sel_neg = xs_q[i] ^ cs_q[i];
         end
      end
      prod = PROD_W'(sel_xm) * PROD_W'(sel_cm);
      // a zero product negates to zero, so sign-magnitude -0 needs no special case
      term = sel_neg ? -$signed(ACC_W'(prod)) : $signed(ACC_W'(prod));
   end

   // ---------------- scale + saturate ----------------
   logic signed [ACC_W-1:0] shifted;
   logic signed [WIDE-1:0]  wide;
   logic [BW_out-1:0]       y_d;
   logic                    sat_d;

   always_comb begin
      shifted = acc_q >>> SHIFT;   // floor toward -inf
      wide    = WIDE'(shifted);
      y_d     = wide[BW_out-1:0];
      sat_d   = 1'b0;
      if (wide > Y_MAX) begin
         y_d   = Y_MAX[BW_out-1:0];
         sat_d = 1'b1;
      end else if (wide < Y_MIN) begin
         y_d   = Y_MIN[BW_out-1:0];
         sat_d = 1'b1;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         xm_q      <= '0;
         cm_q      <= '0;
         xs_q      <= '0;
         cs_q      <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         y_valid_q <= 1'b0;
         y_out_q   <= '0;
         sat_q     <= 1'b0;
      end else begin
         y_valid_q <= out_en;
         if (load) begin
            xm_q  <= bus.x_mag;
            cm_q  <= bus.c_mag;
            xs_q  <= bus.x_sign;
            cs_q  <= bus.c_sign;
            idx_q <= '0;
            acc_q <= '0;
         end
         if (mac_en) begin
            acc_q <= acc_q + term;
            idx_q <= idx_q + IDX_W'(1);
         end
         if (out_en) begin
            y_out_q <= y_d;
            sat_q   <= sat_d;
         end
      end
   end

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.y_valid = y_valid_q;
   assign bus.y_out   = y_out_q;
   assign bus.sat     = sat_q;

endmodule

// File: tb/tb_fir_mac_serial.sv
// ----------------------------------------------------------------------------
// tb_fir_mac_serial
//   Directed + random bench for fir_mac_serial at default parameters.
//   Expected results come from a plain-integer sum-of-products model.
// ----------------------------------------------------------------------------
module tb_fir_mac_serial;
   localparam int N      = 5;
   localparam int BW_in  = 6;
   localparam int BW_out = 8;
   localparam int SHIFT  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_mac_serial_if #(.N_TAPS(N), .BW_in(BW_in), .BW_out(BW_out)) bus();

   fir_mac_serial #(.N_TAPS(N), .BW_in(BW_in), .BW_out(BW_out), .SHIFT(SHIFT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int xm[N], xs[N], cm[N], cs[N];

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference: y = clamp(floor(sum(+-x*c) / 2^SHIFT))
   task automatic model(output int y, output int s);
      int acc, sh, lim_hi, lim_lo;
      acc = 0;
      for (int i = 0; i < N; i++)
         acc += ((xs[i] ^ cs[i]) != 0) ? -(xm[i]*cm[i]) : xm[i]*cm[i];
      sh = acc >>> SHIFT;
      lim_hi = (1 << (BW_out-1)) - 1;
      lim_lo = -(1 << (BW_out-1));
      s = 0;
      y = sh;
      if (sh > lim_hi) begin y = lim_hi; s = 1; end
      if (sh < lim_lo) begin y = lim_lo; s = 1; end
   endtask

   task automatic drive_bus();
      for (int i = 0; i < N; i++) begin
         bus.x_mag[i*BW_in +: BW_in] = BW_in'(xm[i]);
         bus.c_mag[i*BW_in +: BW_in] = BW_in'(cm[i]);
         bus.x_sign[i] = xs[i][0];
         bus.c_sign[i] = cs[i][0];
      end
   endtask

   task automatic scramble();
      bus.x_mag  = (N*BW_in)'($urandom);
      bus.c_mag  = (N*BW_in)'($urandom);
      bus.x_sign = N'($urandom);
      bus.c_sign = N'($urandom);
   endtask

   task automatic randomize_taps();
      for (int i = 0; i < N; i++) begin
         xm[i] = $urandom_range(0, 63);
         cm[i] = $urandom_range(0, 63);
         xs[i] = $urandom_range(0, 1);
         cs[i] = $urandom_range(0, 1);
      end
   endtask

   // one start pulse; inputs scrambled right after the start edge.
   // poke=1 also raises start for one cycle while busy.
   task automatic run_eval(input string tag, input bit poke);
      int ey, es, lat, extra;
      model(ey, es);
      @(negedge clk);
      drive_bus();
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      scramble();
      chk({tag, ".busy"}, bus.busy, 1);
      lat = 0;
      while (bus.y_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
         bus.start = (poke && lat == 2);
      end
      bus.start = 1'b0;
      chk({tag, ".lat"}, lat, N+1);
      chk({tag, ".y"}, $signed(bus.y_out), ey);
      chk({tag, ".sat"}, bus.sat, es);
      @(negedge clk);
      chk({tag, ".pulse"}, bus.y_valid, 0);
      chk({tag, ".idle"}, bus.busy, 0);
      if (poke) begin
         extra = 0;
         for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.y_valid === 1'b1) extra++;
         end
         chk({tag, ".noextra"}, extra, 0);
      end
   endtask

   task automatic set_test1();
      xm = '{16, 16, 16, 16, 16};
      cm = '{1, 2, 3, 4, 5};
      xs = '{0, 0, 0, 0, 0};
      cs = '{0, 0, 0, 0, 0};
   endtask

   initial begin
      int ey, es, npulse, extra;

      // ---- reset ----
      reset = 1'b1;
      bus.start = 1'b0;
      bus.x_mag = '0; bus.c_mag = '0; bus.x_sign = '0; bus.c_sign = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.busy", bus.busy, 0);
      chk("rst.valid", bus.y_valid, 0);
      chk("rst.y", $signed(bus.y_out), 0);
      chk("rst.sat", bus.sat, 0);
      reset = 1'b0;

      // ---- directed ----
      set_test1();
      model(ey, es);
      chk("model.t1", ey, 15);                  // guards the model itself
      run_eval("t1", 0);
      xs[0] = 1;
      run_eval("t2", 0);
      xm = '{31, 31, 31, 31, 31};
      cm = '{31, 31, 31, 31, 31};
      xs = '{0, 0, 0, 0, 0};
      run_eval("t3pos", 0);
      xs = '{1, 1, 1, 1, 1};
      run_eval("t3neg", 0);
      xm = '{1, 0, 0, 0, 0};
      cm = '{1, 0, 0, 0, 0};
      xs = '{1, 1, 1, 1, 1};              // negative zeros on taps 1..4
      cs = '{0, 0, 0, 0, 1};
      run_eval("t4floor", 0);
      xm[0] = 32; cm[0] = 32;
      run_eval("t4m64", 0);

      // ---- random, with a start poke while busy on some runs ----
      for (int r = 0; r < 8; r++) begin
         randomize_taps();
         run_eval($sformatf("rnd%0d", r), r[0]);
      end

      // ---- start held high: one result every N+2 clocks ----
      randomize_taps();
      model(ey, es);
      @(negedge clk);
      drive_bus();
      bus.start = 1'b1;
      @(posedge clk);
      npulse = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (bus.y_valid === 1'b1) begin
            chk($sformatf("hold.t%0d", npulse), t, 6 + 7*npulse);
            chk($sformatf("hold.y%0d", npulse), $signed(bus.y_out), ey);
            npulse++;
         end
      end
      bus.start = 1'b0;
      chk("hold.count", npulse, 4);
      extra = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         if (bus.y_valid === 1'b1) extra++;
      end
      chk("hold.drain", extra, 1);             // the run started on the last edge

      // ---- reset in the 3rd MAC cycle ----
      xm = '{20, 20, 20, 20, 20};
      cm = '{3, 3, 3, 3, 3};
      xs = '{0, 0, 0, 0, 0};
      cs = '{0, 0, 0, 0, 0};
      run_eval("pre_rst", 0);                  // leaves y_out nonzero
      @(negedge clk);
      drive_bus();
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);                          // MAC cycle 1
      bus.start = 1'b0;
      @(negedge clk);                          // MAC cycle 2
      @(negedge clk);                          // MAC cycle 3
      reset = 1'b1;
      @(negedge clk);
      chk("mrst.busy", bus.busy, 0);
      chk("mrst.valid", bus.y_valid, 0);
      chk("mrst.y", $signed(bus.y_out), 0);
      chk("mrst.sat", bus.sat, 0);
      reset = 1'b0;
      extra = 0;
      for (int t = 0; t < N+4; t++) begin
         @(negedge clk);
         if (bus.y_valid === 1'b1) extra++;
      end
      chk("mrst.novalid", extra, 0);
      set_test1();
      run_eval("post_rst", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
